// File: rtl/aes_round_stage.sv
`default_nettype none
// ============================================================================
//  Module   : aes_round_stage
//  Purpose  : One AES-128 encryption round with a single output register.
//             Datapath: SubBytes -> ShiftRows -> MixColumns (skipped on the
//             final round) -> AddRoundKey, captured one clock after in_valid.
//  Ports    :
//    clk          in   1    rising-edge clock
//    rst_n        in   1    asynchronous active-low reset
//    disable_mix  in   1    1 = final round (MixColumns bypassed)
//    in_valid     in   1    capture qualifier for in_state/round_key/mode
//    in_state     in   128  round input state (byte 0 in bits [127:120])
//    round_key    in   128  AddRoundKey operand
//    out_state    out  128  registered round result, held between results
//    out_valid    out  1    one-cycle strobe per captured result
//  Revision : 1.0  initial release
// ============================================================================
module aes_round_stage (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         disable_mix,
  input  logic         in_valid,
  input  logic [127:0] in_state,
  input  logic [127:0] round_key,
  output logic [127:0] out_state,
  output logic         out_valid
);

  // Forward S-box; index 0 sits at the MSB end of the packed vector.
  localparam logic [0:255][7:0] c_SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by {02} in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0]   w_sb [16];   // after SubBytes, indexed by FIPS byte number
  logic [7:0]   w_sr [16];   // after ShiftRows
  logic [7:0]   w_mc [16];   // after MixColumns
  logic [127:0] w_result;    // after AddRoundKey

  logic [127:0] r_out_state;
  logic         r_out_valid;

  // SubBytes: byte k lives in bits [127-8k -: 8].
  genvar k;
  generate
    for (k = 0; k < 16; k++) begin : g_sub
      assign w_sb[k] = c_SBOX[in_state[127-8*k -: 8]];
    end
  endgenerate

  // ShiftRows: byte (row r, col c) = 4c+r takes the byte from column
  // (c+r) mod 4 of the same row, i.e. row r rotates left by r.
  genvar r, c;
  generate
    for (c = 0; c < 4; c++) begin : g_shift_col
      for (r = 0; r < 4; r++) begin : g_shift_row
        assign w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
      end
    end
  endgenerate

  // MixColumns: circulant [02 03 01 01]; {03}x = {02}x ^ x.
  genvar m;
  generate
    for (m = 0; m < 4; m++) begin : g_mix
      logic [7:0] w_a0, w_a1, w_a2, w_a3;
      assign w_a0 = w_sr[4*m+0];
      assign w_a1 = w_sr[4*m+1];
      assign w_a2 = w_sr[4*m+2];
      assign w_a3 = w_sr[4*m+3];
      assign w_mc[4*m+0] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
      assign w_mc[4*m+1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
      assign w_mc[4*m+2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
      assign w_mc[4*m+3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end
  endgenerate

  // Final-round bypass and AddRoundKey, repacked into the 128-bit vector.
  genvar j;
  generate
    for (j = 0; j < 16; j++) begin : g_ark
      assign w_result[127-8*j -: 8] = (disable_mix ? w_sr[j] : w_mc[j])
                                      ^ round_key[127-8*j -: 8];
    end
  endgenerate

  // The only storage in the stage: result register and its valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_state <= 128'h0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out_state <= w_result;
      end
    end
  end

  assign out_state = r_out_state;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_round_stage
//  Purpose  : Directed, table-driven self-checking bench for aes_round_stage
//             using FIPS-197 Appendix B round values and hand-derived vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_round_stage;

  logic         clk;
  logic         rst_n;
  logic         disable_mix;
  logic         in_valid;
  logic [127:0] in_state;
  logic [127:0] round_key;
  logic [127:0] out_state;
  logic         out_valid;

  int n_cmp;
  int n_err;

  typedef struct {
    logic         dm;
    logic [127:0] st;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [8];

  aes_round_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .disable_mix (disable_mix),
    .in_valid    (in_valid),
    .in_state    (in_state),
    .round_key   (round_key),
    .out_state   (out_state),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_state(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_valid(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic dm, input logic [127:0] st, input logic [127:0] key);
    in_valid    = v;
    disable_mix = dm;
    in_state    = st;
    round_key   = key;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    tbl[0] = '{1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'ha0fafe1788542cb123a339392a6c7605,
               128'ha49c7ff2689f352b6b5bea43026a5049};
    tbl[1] = '{1'b1, 128'heb40f21e592e38848ba113e71bc342d2, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
               128'h3925841d02dc09fbdc118597196a0b32};
    tbl[2] = '{1'b0, 128'h0, 128'h0, {16{8'h63}}};
    tbl[3] = '{1'b1, 128'h0, 128'h0, {16{8'h63}}};
    // FIPS round-1 input with zero key: bare ShiftRows output, then MixColumns output.
    tbl[4] = '{1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'h0,
               128'hd4bf5d30e0b452aeb84111f11e2798e5};
    tbl[5] = '{1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'h0,
               128'h046681e5e0cb199a48f8d37a2806264c};
    tbl[6] = '{1'b0, 128'h0, {16{8'hff}}, {16{8'h9c}}};
    tbl[7] = '{1'b1, {16{8'h53}}, 128'h0, {16{8'hed}}};

    // Reset with toggling inputs: outputs must be zero without any edge.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, {16{8'ha5}}, {16{8'h5a}});
    #2;
    chk_state("reset_state_t0", out_state, 128'h0);
    chk_valid("reset_valid_t0", out_valid, 1'b0);
    repeat (2) begin
      @(negedge clk);
      drive(1'b1, ~disable_mix, ~in_state, ~round_key);
    end
    @(posedge clk); #1;
    chk_state("reset_state_clk", out_state, 128'h0);
    chk_valid("reset_valid_clk", out_valid, 1'b0);

    @(negedge clk);
    drive(1'b0, 1'b0, 128'h0, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_valid("idle_valid", out_valid, 1'b0);

    // Table vectors, applied back-to-back (one result per clock).
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, tbl[i].dm, tbl[i].st, tbl[i].key);
      @(posedge clk); #1;
      chk_state($sformatf("vec%0d_state", i), out_state, tbl[i].exp);
      chk_valid($sformatf("vec%0d_valid", i), out_valid, 1'b1);
    end

    // Streaming full round then final round, then three idle cycles of hold.
    @(negedge clk);
    drive(1'b1, tbl[0].dm, tbl[0].st, tbl[0].key);
    @(posedge clk); #1;
    chk_state("stream_a_state", out_state, tbl[0].exp);
    chk_valid("stream_a_valid", out_valid, 1'b1);
    @(negedge clk);
    drive(1'b1, tbl[1].dm, tbl[1].st, tbl[1].key);
    @(posedge clk); #1;
    chk_state("stream_b_state", out_state, tbl[1].exp);
    chk_valid("stream_b_valid", out_valid, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, tbl[0].st, tbl[0].key);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_state($sformatf("hold%0d_state", i), out_state, 128'h3925841d02dc09fbdc118597196a0b32);
      chk_valid($sformatf("hold%0d_valid", i), out_valid, 1'b0);
    end

    // Reset mid-stream: capture a result, pulse reset, then resume.
    @(negedge clk);
    drive(1'b1, tbl[0].dm, tbl[0].st, tbl[0].key);
    @(posedge clk); #1;
    chk_state("pre_rst_state", out_state, tbl[0].exp);
    #1;
    rst_n = 1'b0;
    #1;
    chk_state("mid_rst_state", out_state, 128'h0);
    chk_valid("mid_rst_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    chk_state("rst_hold_state", out_state, 128'h0);
    chk_valid("rst_hold_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, tbl[1].dm, tbl[1].st, tbl[1].key);
    @(posedge clk); #1;
    chk_state("post_rst_state", out_state, tbl[1].exp);
    chk_valid("post_rst_valid", out_valid, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 128'h0, 128'h0);
    @(posedge clk); #1;
    chk_valid("post_rst_idle", out_valid, 1'b0);
    chk_state("post_rst_hold", out_state, tbl[1].exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
